// File: rtl/music_step_sequencer_pkg.sv
// Shared types for the music-box step sequencer: FSM states and step width.
`timescale 1ns/1ps
package music_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int STEP_W = 4;
endpackage

// File: rtl/music_step_sequencer_if.sv
// Command/status bundle between the playback controller and the sequencer.
`timescale 1ns/1ps
interface music_step_sequencer_if;
    import music_pkg::*;

    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [1:0]        tempo_sel;
    logic [STEP_W-1:0] step;
    logic              step_valid;
    logic              step_strobe;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, pause, loop_en, tempo_sel,
        input  step, step_valid, step_strobe, busy, done
    );

    modport slave (
        input  start, stop, pause, loop_en, tempo_sel,
        output step, step_valid, step_strobe, busy, done
    );
endinterface

// File: rtl/music_step_sequencer_tick_gen.sv
// Prescaler: divides clk down to one tick every CLK_PER_TICK enabled cycles.
`timescale 1ns/1ps
module music_tick_gen #(
    parameter int CLK_PER_TICK = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

    logic [PW-1:0] r_cnt;

    // Gated by en so a frozen prescaler sitting on its last count never fires.
    assign tick = en && (r_cnt == PW'(CLK_PER_TICK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= tick ? '0 : r_cnt + PW'(1);
    end
endmodule

// File: rtl/music_step_sequencer.sv
// Step sequencer: walks steps 0..LAST_STEP, each held BASE_TICKS>>tempo ticks.
`timescale 1ns/1ps
module music_step_sequencer
    import music_pkg::*;
#(
    parameter int CLK_PER_TICK = 1000,
    parameter int BASE_TICKS   = 8,
    parameter int LAST_STEP    = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    music_step_sequencer_if.slave  io_seq
);
    localparam int TW = $clog2(BASE_TICKS);

    state_t            r_state;
    logic [TW-1:0]     r_tcnt;
    logic [1:0]        r_tempo;
    logic [STEP_W-1:0] r_step;
    logic              r_strobe;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_start;
    logic              w_run;
    logic              w_tick;
    logic [TW:0]       w_len;
    logic [TW:0]       w_len_m1;
    logic              w_bound;

    assign w_start  = ((r_state == IDLE) || (r_state == DONE)) && io_seq.start && !io_seq.stop;
    // Leaving PAUSE counts on the same edge, so a pause of N cycles stretches the step by exactly N.
    assign w_run    = ((r_state == PLAY) || (r_state == PAUSE)) && !io_seq.pause && !io_seq.stop;
    assign w_len    = (TW+1)'(BASE_TICKS) >> r_tempo;
    assign w_len_m1 = w_len - (TW+1)'(1);
    assign w_bound  = w_tick && ({1'b0, r_tcnt} == w_len_m1);

    music_tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_run),
        .clr   (w_start || io_seq.stop),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tcnt   <= '0;
            r_tempo  <= '0;
            r_step   <= '0;
            r_strobe <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (io_seq.stop) begin
                r_state <= IDLE;
                r_tcnt  <= '0;
                r_tempo <= '0;
                r_step  <= '0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (io_seq.start) begin
                            r_state  <= PLAY;
                            r_tcnt   <= '0;
                            r_tempo  <= io_seq.tempo_sel;
                            r_step   <= '0;
                            r_strobe <= 1'b1;
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                        end
                    end
                    PLAY, PAUSE: begin
                        if (io_seq.pause) begin
                            r_state <= PAUSE;
                        end else begin
                            r_state <= PLAY;
                            if (w_bound) begin
                                r_tcnt <= '0;
                                if ((r_step == STEP_W'(LAST_STEP)) && !io_seq.loop_en) begin
                                    r_state <= DONE;
                                    r_valid <= 1'b0;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_step   <= (r_step == STEP_W'(LAST_STEP)) ? '0 : r_step + STEP_W'(1);
                                    r_strobe <= 1'b1;
                                    r_tempo  <= io_seq.tempo_sel;
                                end
                            end else if (w_tick) begin
                                r_tcnt <= r_tcnt + TW'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign io_seq.step        = r_step;
    assign io_seq.step_valid  = r_valid;
    assign io_seq.step_strobe = r_strobe;
    assign io_seq.busy        = r_busy;
    assign io_seq.done        = r_done;
endmodule

// File: tb/tb_music_step_sequencer.sv
// Self-checking bench for music_step_sequencer: vector table, clock-count model scoreboard, corner sequences.
`timescale 1ns/1ps
module tb_music_step_sequencer;
    localparam int CPT = 2;
    localparam int BT  = 8;
    localparam int LS  = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    music_step_sequencer_if sif();

    music_step_sequencer #(.CLK_PER_TICK(CPT), .BASE_TICKS(BT), .LAST_STEP(LS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_seq (sif)
    );

    typedef struct {
        logic       st, sp, pa, lp;
        logic [1:0] tp;
        logic [3:0] e_step;
        logic       e_valid, e_stb, e_busy, e_done;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int ncyc   = 0;
    logic [7:0] exp_q[$];

    // Reference model: tracks clocks elapsed in the current step (0=idle 1=play 2=pause 3=done).
    int   m_st, m_step, m_cnt, m_len;
    logic m_stb;

    function automatic logic [7:0] dut_out();
        return {sif.step, sif.step_valid, sif.step_strobe, sif.busy, sif.done};
    endfunction

    function automatic logic [7:0] model_out();
        logic b;
        b = (m_st == 1) || (m_st == 2);
        return {4'(m_step), b, m_stb, b, (m_st == 3)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_step = 0; m_cnt = 0; m_len = 0; m_stb = 1'b0;
    endtask

    task automatic model_step(input logic st, sp, pa, lp, input logic [1:0] tp);
        m_stb = 1'b0;
        if (sp) begin
            model_reset();
        end else if ((m_st == 0 || m_st == 3) && st) begin
            m_st = 1; m_step = 0; m_cnt = 0; m_len = CPT * (BT >> tp); m_stb = 1'b1;
        end else if (m_st == 1 || m_st == 2) begin
            if (pa) begin
                m_st = 2;
            end else begin
                m_st  = 1;
                m_cnt = m_cnt + 1;
                if (m_cnt == m_len) begin
                    m_cnt = 0;
                    if (m_step == LS && !lp) begin
                        m_st = 3;
                    end else begin
                        m_step = (m_step == LS) ? 0 : m_step + 1;
                        m_stb  = 1'b1;
                        m_len  = CPT * (BT >> tp);
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic st, sp, pa, lp, input logic [1:0] tp,
                       input string tag = "model", input bit use_t = 1'b0,
                       input logic [7:0] t_exp = 8'h00);
        logic [7:0] e;
        sif.start = st; sif.stop = sp; sif.pause = pa; sif.loop_en = lp; sif.tempo_sel = tp;
        model_step(st, sp, pa, lp, tp);
        exp_q.push_back(use_t ? t_exp : model_out());
        @(posedge clk);
        #1;
        ncyc++;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty at cycle %0d", tag, ncyc);
        end else begin
            e = exp_q.pop_front();
            if (dut_out() !== e) begin
                n_fail++;
                $display("FAIL %s: cycle %0d got {step,valid,strobe,busy,done}=%h expected %h",
                         tag, ncyc, dut_out(), e);
            end
        end
    endtask

    vec_t tbl[11];
    int   t0, done_at, nstb, wrap_at, done_seen, s_at, vmin;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        sif.start = 0; sif.stop = 0; sif.pause = 0; sif.loop_en = 0; sif.tempo_sel = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'(dut_out()), 0);
        rst_n = 1'b1;

        // Short-tempo steps, mid-step tempo change, ignored restart, stop-beats-start, start+pause
        foreach (tbl[i])
            cyc(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].lp, tbl[i].tp, $sformatf("vec%0d", i), 1'b1,
                {tbl[i].e_step, tbl[i].e_valid, tbl[i].e_stb, tbl[i].e_busy, tbl[i].e_done});

        // Tempo 3 then switch to 0 mid-step: old length finishes, next step is 16 clocks
        cyc(1, 0, 0, 0, 3);
        t0 = ncyc;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_step1_at", (sif.step_strobe && sif.step == 4'd1) ? ncyc - t0 + 1 : -1, 3);
        s_at = ncyc; done_at = -1;
        for (int k = 0; k < 40 && done_at < 0; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (sif.step_strobe) done_at = ncyc - s_at;
        end
        chk("t4_step1_len", done_at, 16);

        // Full run, no loop
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        t0 = ncyc; done_at = -1; nstb = 1;
        for (int k = 0; k < 270; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (sif.step_strobe) nstb++;
            if (sif.done && done_at < 0) done_at = ncyc - t0 + 1;
        end
        chk("t1_done_cycle", done_at, 257);
        chk("t1_strobes", nstb, 16);
        chk("t1_step_hold", int'(sif.step), 15);
        chk("t1_valid_low", int'(sif.step_valid), 0);

        // Loop: wrap to 0 at cycle 257, never done
        cyc(1, 0, 0, 1, 0);
        t0 = ncyc; wrap_at = -1; done_seen = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(0, 0, 0, 1, 0);
            if (sif.done) done_seen = 1;
            if (sif.step_strobe && sif.step == 4'd0 && wrap_at < 0) wrap_at = ncyc - t0 + 1;
        end
        chk("t2_wrap_cycle", wrap_at, 257);
        chk("t2_done_seen", done_seen, 0);
        chk("t2_busy", int'(sif.busy), 1);

        // Pause 10 cycles inside step 3
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (48) cyc(0, 0, 0, 0, 0);
        chk("t3_at_step3", (sif.step_strobe && sif.step == 4'd3) ? 1 : 0, 1);
        s_at = ncyc; vmin = 1;
        repeat (4) cyc(0, 0, 0, 0, 0);
        repeat (10) begin
            cyc(0, 0, 1, 0, 0);
            if (!sif.step_valid || !sif.busy) vmin = 0;
        end
        done_at = -1;
        for (int k = 0; k < 60 && done_at < 0; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (sif.step_strobe) done_at = ncyc - s_at;
        end
        chk("t3_step3_len", done_at, 26);
        chk("t3_valid_held", vmin, 1);
        chk("t3_next_step", int'(sif.step), 4);

        // Async reset mid step 7
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (117) cyc(0, 0, 0, 0, 0);
        chk("t6_pre_step", int'(sif.step), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_reset", int'(dut_out()), 0);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) cyc(0, 0, 0, 0, 0, "t6_idle");
        cyc(1, 0, 0, 0, 0, "t6_restart");
        repeat (3) cyc(0, 0, 0, 0, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
